adder_arbiter: RTL and testbench
================================

// Module: adder_arbiter
// PURPOSE
//  Shares one combinational 4-bit `adder` instance among NUM_REQ requesters.
//  - Arbitration: round-robin.
//  - Each requester presents operands a/b and receives the 5-bit sum tagged with its ID.
//  - Returns the result through a one-deep response register with valid/ready backpressure.
//  - Sits between requesting units and the shared adder datapath; owns sequencing of adder inputs.
// PARAMETERS
//  NUM_REQ  4                  number of requesters (2..8)
//  WIDTH    4                  operand width; fixed to the adder datapath width
//  ID_W     $clog2(NUM_REQ)    requester ID width
//  CNT_W    8                  grant counter width (ADDER_ARB_PERF_EN only)
// PORTS
//  clk          in   1                 clock, rising edge
//  rst_n        in   1                 synchronous reset, active low
//  req_valid_i  in   NUM_REQ           per-requester request valid
//  req_ready_o  out  NUM_REQ           per-requester accept, one-hot or zero
//  req_a_i      in   NUM_REQ*WIDTH     operand a; slice i belongs to requester i
//  req_b_i      in   NUM_REQ*WIDTH     operand b; slice i belongs to requester i
//  rsp_valid_o  out  1                 response valid
//  rsp_ready_i  in   1                 response consumer ready
//  rsp_sum_o    out  WIDTH+1           a+b, with carry in MSB
//  rsp_id_o     out  ID_W              index of requester owning the response
//  busy_o       out  1                 high whenever state != IDLE
// BEHAVIOUR
//  Reset
//   - All registered state and outputs clear on the first clk edge with rst_n=0.
//   - rsp_valid_o=0, rsp_sum_o=0, rsp_id_o=0, busy_o=0, req_ready_o=0, state=IDLE, rr pointer=0.
//   - Reset mid-operation discards the in-flight operation; no response is produced for it.
//  FSM states: IDLE -> EXEC -> RESP -> IDLE
//  IDLE
//   - req_ready_o is driven combinationally: a one-hot grant to the first valid requester
//     at or after the rr pointer, wrapping at NUM_REQ-1 -> 0.
//   - On any grant: latch operand slices into op_a/op_b regs, latch the grant ID,
//     set pointer=(id+1)%NUM_REQ, go to EXEC.
//   - No valid requesters: stay in IDLE; pointer unchanged.
//  EXEC
//   - op regs drive the adder a_i/b_i.
//   - sum_o is registered into rsp_sum_o; rsp_valid_o=1 from the next cycle; go to RESP.
//  RESP
//   - Hold rsp_valid_o, rsp_sum_o and rsp_id_o stable until rsp_ready_i=1.
//   - On that cycle: go to IDLE and drop rsp_valid_o on the next edge.
//   - No grant is issued in RESP; req_ready_o=0 in EXEC and RESP.
//  Latency and throughput
//   - Request handshake in cycle T -> rsp_valid_o high in cycle T+2.
//   - Maximum throughput is one operation per 3 cycles.
//  Requester rules
//   - Requesters hold valid and operands stable until ready.
//   - Deasserting valid without a grant is legal and loses nothing.
//  Arithmetic: unsigned; rsp_sum_o = {carry, sum[WIDTH-1:0]}; 4'hF+4'hF=5'h1E; no saturation.
//  Arbitration: simultaneous requests are resolved only by the pointer; starvation-free,
//   worst-case wait is NUM_REQ-1 grants.
// CONFIGURATION
//  ADDER_ARB_PERF_EN defined
//   - Adds output grant_cnt_o [NUM_REQ*CNT_W]: per-requester grant counters.
//   - A counter increments on each grant to its requester and wraps at 2^CNT_W.
//   - Counters clear on reset.
//  ADDER_ARB_PERF_EN undefined
//   - grant_cnt_o port and counters are absent; all other behaviour is identical.
// STRUCTURE
//  Package adder_arb_pkg
//   - typedef enum logic [1:0] {IDLE, EXEC, RESP} arb_state_e;
//   - localparams for default WIDTH=4 and CNT_W=8.
//  Sub-module adder_rr_arb (NUM_REQ)
//   - Inputs: req vector, enable (state==IDLE).
//   - Outputs: one-hot grant, grant ID, grant_any.
//   - Owns the rr pointer register.
//  Top level: instantiates adder_rr_arb and the existing `adder`; holds the FSM, op regs and rsp regs.
// TESTING
//  1. Single request: reset; req0 a=3 b=5 -> req_ready_o=4'b0001 same cycle;
//     rsp_valid at T+2, sum=8, id=0.
//  2. Carry: req2 a=F b=F -> rsp_sum_o=5'h1E, id=2.
//  3. Round-robin: all 4 valid continuously, rsp_ready_i=1 -> grant order 0,1,2,3,0;
//     a new grant every 3 cycles.
//  4. Backpressure: rsp_ready_i=0 for 5 cycles during RESP -> sum/id stay stable,
//     no req_ready_o issued; release -> IDLE next cycle.
//  5. Reset mid-op: rst_n=0 in EXEC -> next cycle all outputs 0, no response,
//     and the next grant goes to requester 0.
//  6. PERF (macro defined): 3 grants to req1 and 1 to req3 -> grant_cnt_o[1]=3, [3]=1,
//     others 0; reset clears all counters.

Source files
------------

// File: rtl/adder_arb_pkg.sv
// adder_arb_pkg: shared FSM state type and default widths for the adder arbiter.
package adder_arb_pkg;
    typedef enum logic [1:0] {IDLE, EXEC, RESP} arb_state_e;
    localparam int DEF_WIDTH = 4;
    localparam int DEF_CNT_W = 8;
endpackage

// File: rtl/adder.sv
// adder: existing 4-bit combinational adder datapath.
// Ports: a_i, b_i operands; sum_o = {carry, sum}.
module adder (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    output logic [4:0] sum_o
);
    assign sum_o = {1'b0, a_i} + {1'b0, b_i};
endmodule

// File: rtl/adder_rr_arb.sv
// adder_rr_arb: round-robin grant generator that owns the rotating priority pointer.
// Ports: clk, rst_n (sync, active low); req requests; en allows a grant;
//        grant one-hot (zero when none); grant_id index of grant; grant_any any grant.
module adder_rr_arb #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               grant_any
);
    logic [ID_W-1:0] ptr_q;
    // Scan from farthest to nearest offset so the requester closest to the pointer wins.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (en && req[(int'(ptr_q) + k) % NUM_REQ]) begin
                grant                                 = '0;
                grant[(int'(ptr_q) + k) % NUM_REQ]    = 1'b1;
                grant_id                              = ID_W'((int'(ptr_q) + k) % NUM_REQ);
            end
        end
    end
    assign grant_any = |grant;
    always_ff @(posedge clk) begin
        if (!rst_n)
            ptr_q <= '0;
        else if (grant_any)
            ptr_q <= (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;
    end
endmodule

// File: rtl/adder_arbiter.sv
// adder_arbiter: shares one 4-bit adder among NUM_REQ requesters with round-robin arbitration.
// Ports: clk, rst_n (sync, active low); req_valid_i/req_ready_o per-requester handshake;
//        req_a_i/req_b_i packed operand slices; rsp_valid_o/rsp_ready_i response handshake;
//        rsp_sum_o {carry,sum}; rsp_id_o owner of response; busy_o high outside IDLE.
// Macro ADDER_ARB_PERF_EN adds grant_cnt_o, per-requester wrapping grant counters.
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int ID_W    = $clog2(NUM_REQ)
`ifdef ADDER_ARB_PERF_EN
    , parameter int CNT_W = DEF_CNT_W
`endif
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    input  logic [NUM_REQ*WIDTH-1:0] req_a_i,
    input  logic [NUM_REQ*WIDTH-1:0] req_b_i,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [WIDTH:0]           rsp_sum_o,
    output logic [ID_W-1:0]          rsp_id_o,
    output logic                     busy_o
`ifdef ADDER_ARB_PERF_EN
    , output logic [NUM_REQ*CNT_W-1:0] grant_cnt_o
`endif
);
    arb_state_e          state_q, state_d;
    logic [WIDTH-1:0]    op_a_q, op_b_q;
    logic [ID_W-1:0]     id_q, grant_id;
    logic [NUM_REQ-1:0]  grant;
    logic                grant_any;
    logic [WIDTH:0]      sum;
    // Gating with rst_n keeps req_ready_o low while reset is asserted.
    adder_rr_arb #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req_valid_i),
        .en        (state_q == IDLE && rst_n),
        .grant     (grant),
        .grant_id  (grant_id),
        .grant_any (grant_any)
    );
    adder u_adder (
        .a_i   (op_a_q),
        .b_i   (op_b_q),
        .sum_o (sum)
    );
    assign req_ready_o = grant;
    assign busy_o      = state_q != IDLE;
    always_comb begin
        state_d = state_q;
        state_d = (state_q == IDLE) ? (grant_any ? EXEC : IDLE) :
                  (state_q == EXEC) ? RESP :
                  (rsp_ready_i ? IDLE : RESP);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_a_q      <= '0;
            op_b_q      <= '0;
            id_q        <= '0;
            rsp_valid_o <= 1'b0;
            rsp_sum_o   <= '0;
            rsp_id_o    <= '0;
        end else begin
            state_q <= state_d;
            if (grant_any) begin
                op_a_q <= req_a_i[grant_id*WIDTH +: WIDTH];
                op_b_q <= req_b_i[grant_id*WIDTH +: WIDTH];
                id_q   <= grant_id;
            end
            if (state_q == EXEC) begin
                rsp_valid_o <= 1'b1;
                rsp_sum_o   <= sum;
                rsp_id_o    <= id_q;
            end else if (state_q == RESP && rsp_ready_i) begin
                rsp_valid_o <= 1'b0;
            end
        end
    end
`ifdef ADDER_ARB_PERF_EN
    logic [NUM_REQ-1:0][CNT_W-1:0] cnt_q;
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++)
            cnt_q[i] <= !rst_n ? '0 : cnt_q[i] + CNT_W'(grant[i]);
    end
    assign grant_cnt_o = cnt_q;
`endif
endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: self-checking bench with a transaction-level reference model.
module tb_adder_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [15:0] req_a, req_b;
    logic        rsp_valid, rsp_ready;
    logic [4:0]  rsp_sum;
    logic [1:0]  rsp_id;
    logic        busy;
`ifdef ADDER_ARB_PERF_EN
    logic [31:0] grant_cnt;
`endif
    int n_cmp = 0;
    int n_err = 0;
    int ptr_m = 0;
    adder_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_a_i     (req_a),
        .req_b_i     (req_b),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_sum_o   (rsp_sum),
        .rsp_id_o    (rsp_id),
        .busy_o      (busy)
`ifdef ADDER_ARB_PERF_EN
        , .grant_cnt_o (grant_cnt)
`endif
    );
    always #5 clk = ~clk;
    function automatic int pick(input logic [3:0] m, input int p);
        for (int k = 0; k < 4; k++)
            if (m[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction
    function automatic logic [3:0] onehot(input int id);
        return (id < 0) ? 4'b0000 : 4'(1 << id);
    endfunction
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic test_reset();
        rst_n = 1'b0; req_valid = 4'hF; rsp_ready = 1'b0;
        req_a = '0; req_b = '0;
        tick();
        n_cmp++;
        if ({rsp_valid, rsp_sum, rsp_id, busy, req_ready} !== 13'd0) begin
            n_err++;
            $display("FAIL reset: got valid=%b sum=%h id=%0d busy=%b ready=%b, want all zero",
                     rsp_valid, rsp_sum, rsp_id, busy, req_ready);
        end
        rst_n = 1'b1; req_valid = '0; ptr_m = 0;
        tick();
    endtask
    task automatic test_single(input int id, input logic [3:0] a, input logic [3:0] b);
        req_valid = onehot(id); req_a[id*4 +: 4] = a; req_b[id*4 +: 4] = b; rsp_ready = 1'b1;
        #1;
        n_cmp++;
        if (req_ready !== onehot(pick(req_valid, ptr_m))) begin
            n_err++;
            $display("FAIL single_grant: got %b want %b", req_ready, onehot(pick(req_valid, ptr_m)));
        end
        ptr_m = (id + 1) % 4;
        tick();
        req_valid = '0;
        n_cmp++;
        if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL single_exec: got valid=%b busy=%b want 0/1", rsp_valid, busy);
        end
        tick();
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_sum !== 5'(a + b) || rsp_id !== 2'(id)) begin
            n_err++;
            $display("FAIL single_rsp: got v=%b sum=%h id=%0d want 1 %h %0d",
                     rsp_valid, rsp_sum, rsp_id, 5'(a + b), id);
        end
        tick();
        n_cmp++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL single_done: got valid=%b busy=%b want 0/0", rsp_valid, busy);
        end
    endtask
    task automatic test_round_robin();
        int ids[$];
        int cyc[$];
        rst_n = 1'b0; tick(); rst_n = 1'b1; ptr_m = 0;
        req_valid = 4'hF; rsp_ready = 1'b1;
        for (int c = 0; c < 30 && ids.size() < 5; c++) begin
            #1;
            if (req_ready != 0) begin
                for (int i = 0; i < 4; i++) if (req_ready[i]) ids.push_back(i);
                cyc.push_back(c);
            end
            tick();
        end
        n_cmp++;
        if (ids.size() != 5) begin
            n_err++;
            $display("FAIL rr_count: got %0d grants want 5", ids.size());
        end else begin
            for (int g = 0; g < 5; g++) begin
                n_cmp++;
                if (ids[g] != pick(4'hF, ptr_m)) begin
                    n_err++;
                    $display("FAIL rr_order[%0d]: got %0d want %0d", g, ids[g], pick(4'hF, ptr_m));
                end
                ptr_m = (pick(4'hF, ptr_m) + 1) % 4;
                if (g > 0) begin
                    n_cmp++;
                    if (cyc[g] - cyc[g-1] != 3) begin
                        n_err++;
                        $display("FAIL rr_spacing[%0d]: got %0d want 3", g, cyc[g] - cyc[g-1]);
                    end
                end
            end
        end
        req_valid = '0;
        for (int c = 0; c < 4; c++) tick();
    endtask
    task automatic test_backpressure();
        int id;
        req_valid = 4'b0010; req_a[7:4] = 4'h9; req_b[7:4] = 4'hA; rsp_ready = 1'b0;
        #1;
        id = pick(req_valid, ptr_m);
        ptr_m = (id + 1) % 4;
        tick();
        req_valid = 4'hF;
        tick();
        for (int s = 0; s < 5; s++) begin
            n_cmp++;
            if (rsp_valid !== 1'b1 || rsp_sum !== 5'h13 || rsp_id !== 2'(id) || req_ready !== 4'b0) begin
                n_err++;
                $display("FAIL bp_hold[%0d]: got v=%b sum=%h id=%0d rdy=%b want 1 13 %0d 0000",
                         s, rsp_valid, rsp_sum, rsp_id, req_ready, id);
            end
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        n_cmp++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== onehot(pick(4'hF, ptr_m))) begin
            n_err++;
            $display("FAIL bp_release: got v=%b busy=%b rdy=%b want 0 0 %b",
                     rsp_valid, busy, req_ready, onehot(pick(4'hF, ptr_m)));
        end
        req_valid = '0;
        tick();
    endtask
    task automatic test_reset_mid_op();
        req_valid = 4'b1000; req_a[15:12] = 4'h7; req_b[15:12] = 4'h6; rsp_ready = 1'b1;
        tick();
        req_valid = 4'hF;
        rst_n = 1'b0;
        tick();
        n_cmp++;
        if ({rsp_valid, rsp_sum, rsp_id, busy, req_ready} !== 13'd0) begin
            n_err++;
            $display("FAIL midrst_out: got v=%b sum=%h id=%0d busy=%b rdy=%b want zero",
                     rsp_valid, rsp_sum, rsp_id, busy, req_ready);
        end
        rst_n = 1'b1; req_valid = '0; ptr_m = 0;
        for (int c = 0; c < 3; c++) begin
            n_cmp++;
            if (rsp_valid !== 1'b0) begin
                n_err++;
                $display("FAIL midrst_norsp[%0d]: got %b want 0", c, rsp_valid);
            end
            tick();
        end
        req_valid = 4'hF;
        #1;
        n_cmp++;
        if (req_ready !== onehot(pick(4'hF, ptr_m))) begin
            n_err++;
            $display("FAIL midrst_grant: got %b want %b", req_ready, onehot(pick(4'hF, ptr_m)));
        end
        ptr_m = (pick(4'hF, ptr_m) + 1) % 4;
        tick();
        req_valid = '0;
        for (int c = 0; c < 3; c++) tick();
    endtask
    task automatic test_random();
        logic [3:0] m;
        int id, stalls;
        for (int it = 0; it < 40; it++) begin
            m = 4'($urandom_range(0, 15));
            req_a = 16'($urandom); req_b = 16'($urandom);
            req_valid = m; rsp_ready = 1'b0;
            #1;
            id = pick(m, ptr_m);
            n_cmp++;
            if (req_ready !== onehot(id)) begin
                n_err++;
                $display("FAIL rnd_grant[%0d]: mask=%b got %b want %b", it, m, req_ready, onehot(id));
            end
            if (id >= 0) begin
                ptr_m = (id + 1) % 4;
                tick();
                req_valid = m & ~onehot(id);
                tick();
                stalls = $urandom_range(0, 3);
                for (int s = 0; s <= stalls; s++) begin
                    n_cmp++;
                    if (rsp_valid !== 1'b1 || rsp_sum !== 5'(req_a[id*4 +: 4] + req_b[id*4 +: 4]) ||
                        rsp_id !== 2'(id) || req_ready !== 4'b0) begin
                        n_err++;
                        $display("FAIL rnd_rsp[%0d]: got v=%b sum=%h id=%0d rdy=%b want 1 %h %0d 0000",
                                 it, rsp_valid, rsp_sum, rsp_id, req_ready,
                                 5'(req_a[id*4 +: 4] + req_b[id*4 +: 4]), id);
                    end
                    if (s == stalls) rsp_ready = 1'b1;
                    tick();
                end
                rsp_ready = 1'b0;
            end else begin
                tick();
            end
            n_cmp++;
            if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
                n_err++;
                $display("FAIL rnd_idle[%0d]: got busy=%b v=%b want 0 0", it, busy, rsp_valid);
            end
        end
        req_valid = '0;
    endtask
`ifdef ADDER_ARB_PERF_EN
    task automatic test_perf();
        int who[4] = '{1, 1, 1, 3};
        int exp_cnt[4];
        rst_n = 1'b0; tick(); rst_n = 1'b1; ptr_m = 0;
        exp_cnt = '{0, 0, 0, 0};
        rsp_ready = 1'b1;
        foreach (who[g]) begin
            req_valid = onehot(who[g]);
            exp_cnt[who[g]]++;
            tick();
            req_valid = '0;
            tick(); tick();
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (grant_cnt[i*8 +: 8] !== 8'(exp_cnt[i])) begin
                n_err++;
                $display("FAIL perf_cnt[%0d]: got %0d want %0d", i, grant_cnt[i*8 +: 8], exp_cnt[i]);
            end
        end
        rst_n = 1'b0; tick(); rst_n = 1'b1; ptr_m = 0;
        n_cmp++;
        if (grant_cnt !== 32'd0) begin
            n_err++;
            $display("FAIL perf_clear: got %h want 0", grant_cnt);
        end
    endtask
`endif
    initial begin
        test_reset();
        test_single(0, 4'h3, 4'h5);
        test_single(2, 4'hF, 4'hF);
        test_round_robin();
        test_backpressure();
        test_reset_mid_op();
        test_random();
`ifdef ADDER_ARB_PERF_EN
        test_perf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
